// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin arbiter sharing one SPI send path
// among N_REQ requesters, with busy-rise timeout and rx forwarding.
module spi_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_L,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_byte,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_byte,
  output logic               write,
  output logic [7:0]         byte_send,
  input  logic               busy,
  input  logic               valid,
  input  logic [7:0]         byte_recv,
  output logic               active
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WBUSY = 3'd2;
  localparam logic [2:0] S_WDONE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [7:0]    TMO      = 8'(TIMEOUT);
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  logic [2:0]       r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic [N_REQ-1:0] r_err;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [7:0]       r_rsp_byte;
  logic [7:0]       r_byte_send;
  logic [7:0]       r_timer;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    r_own;

  logic             w_found;
  logic [IW-1:0]    w_cand;
  logic [IW-1:0]    w_sel;
  logic [N_REQ-1:0] w_sel_oh;
  logic [7:0]       w_bytes [N_REQ];
  logic [7:0]       w_timer_nx;

  assign w_timer_nx = r_timer + 8'd1;

  // Round-robin pick: first requester at or after last owner + 1.
  always_comb begin
    w_found  = 1'b0;
    w_cand   = '0;
    w_sel    = r_last;
    w_sel_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = IW'((int'(r_last) + 1 + i) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
    w_sel_oh[w_sel] = 1'b1;
  end

  // Split the flat request byte bus per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_bytes[i] = req_byte[8*i +: 8];
    end
  end

  // Transaction FSM: grant, strobe, wait busy rise/fall, report.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_byte_send <= '0;
      r_timer     <= '0;
      r_last      <= LAST_RST;
      r_own       <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found && !busy) begin
            r_gnt       <= w_sel_oh;
            r_byte_send <= w_bytes[w_sel];
            r_own       <= w_sel;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WBUSY;
        end
        S_WBUSY: begin
          if (busy) begin
            r_state <= S_WDONE;
          end else begin
            r_timer <= w_timer_nx;
            if (w_timer_nx == TMO) begin
              r_err   <= r_gnt;
              r_gnt   <= '0;
              r_last  <= r_own;
              r_state <= S_IDLE;
            end
          end
        end
        S_WDONE: begin
          if (!busy) begin
            r_done  <= r_gnt;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_gnt   <= '0;
          r_last  <= r_own;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Forward received bytes to whoever owned the path when sampled.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_rsp_valid <= '0;
      r_rsp_byte  <= '0;
    end else if (r_state != S_IDLE && valid) begin
      r_rsp_valid <= r_gnt;
      r_rsp_byte  <= byte_recv;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign err       = r_err;
  assign rsp_valid = r_rsp_valid;
  assign rsp_byte  = r_rsp_byte;
  assign byte_send = r_byte_send;
  assign write     = (r_state == S_ISSUE);
  assign active    = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: directed and random checks of spi_tx_arbiter
// against a transaction-level model of the arbiter.
module tb_spi_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 255;

  logic           clk = 1'b0;
  logic           rst_L = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_byte = '0;
  logic           busy = 1'b0;
  logic           valid = 1'b0;
  logic [7:0]     byte_recv = '0;
  logic [N-1:0]   gnt, done, err, rsp_valid;
  logic [7:0]     rsp_byte, byte_send;
  logic           write, active;

  spi_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_L(rst_L), .req(req), .req_byte(req_byte),
    .gnt(gnt), .done(done), .err(err), .rsp_valid(rsp_valid),
    .rsp_byte(rsp_byte), .write(write), .byte_send(byte_send),
    .busy(busy), .valid(valid), .byte_recv(byte_recv),
    .active(active)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_done = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  // model: owner (-1 = none), last owner, progress step, wait count
  int m_own, m_last, m_ph, m_wait;
  logic [N-1:0] e_gnt, e_done, e_err, e_rv;
  logic [7:0]   e_rb, e_bs;
  logic         e_write, e_active;

  task automatic model_reset();
    m_own = -1; m_last = N - 1; m_ph = 0; m_wait = 0;
    e_gnt = '0; e_done = '0; e_err = '0; e_rv = '0;
    e_rb = '0; e_bs = '0; e_write = 1'b0; e_active = 1'b0;
  endtask

  task automatic model_step();
    int p;
    e_done = '0; e_err = '0; e_write = 1'b0;
    e_rv = '0;
    if (m_own >= 0 && valid) begin
      e_rv[m_own] = 1'b1;
      e_rb = byte_recv;
    end
    case (m_ph)
      0: if (req != 0 && !busy) begin
        p = -1;
        for (int i = 0; i < N; i++)
          if (p < 0 && req[(m_last + 1 + i) % N]) p = (m_last + 1 + i) % N;
        m_own = p;
        e_bs = req_byte[8*p +: 8];
        e_write = 1'b1;
        m_ph = 1;
      end
      1: begin m_ph = 2; m_wait = 0; end
      2: if (busy) m_ph = 3;
         else begin
           m_wait++;
           if (m_wait == TMO) begin
             e_err[m_own] = 1'b1;
             m_last = m_own; m_own = -1; m_ph = 0;
           end
         end
      3: if (!busy) begin e_done[m_own] = 1'b1; m_ph = 4; end
      default: begin m_last = m_own; m_own = -1; m_ph = 0; end
    endcase
    e_gnt = '0;
    if (m_own >= 0) e_gnt[m_own] = 1'b1;
    e_active = (m_own >= 0);
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("write", 32'(write), 32'(e_write));
    chk("byte_send", 32'(byte_send), 32'(e_bs));
    chk("active", 32'(active), 32'(e_active));
    if (e_rv != 0) chk("rsp_byte", 32'(rsp_byte), 32'(e_rb));
  endtask

  // send-path responder
  bit q[$];
  bit no_rise = 1'b0;
  bit idle_busy = 1'b0;
  int fix_rd = -1;
  int fix_rh = -1;

  task automatic drive_busy();
    int rd, rh;
    if (e_write) begin
      q.delete();
      if (!no_rise) begin
        rd = (fix_rd >= 0) ? fix_rd : int'($urandom_range(0, 3));
        rh = (fix_rh >= 0) ? fix_rh : int'($urandom_range(1, 4));
        q.push_back(1'b0);
        repeat (rd) q.push_back(1'b0);
        repeat (rh) q.push_back(1'b1);
      end
    end
    if (q.size() > 0) busy = q.pop_front();
    else busy = e_active ? 1'b0 : idle_busy;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step();
    check_all();
    if (done != 0) n_done++;
    if (err != 0) n_err++;
    drive_busy();
  endtask

  task automatic wait_for(input int c, input int budget, output int n);
    bit hit;
    hit = 1'b0; n = 0;
    while (!hit && n < budget) begin
      tick();
      n++;
      case (c)
        0: hit = (write == 1'b1);
        1: hit = (done != 0);
        2: hit = (err != 0);
        default: hit = (active == 1'b0);
      endcase
    end
    chk($sformatf("wait_cond%0d", c), 32'(hit), 1);
  endtask

  task automatic do_reset();
    #2;
    rst_L = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rv", 32'(rsp_valid), 0);
    chk("rst_rb", 32'(rsp_byte), 0);
    chk("rst_write", 32'(write), 0);
    chk("rst_bs", 32'(byte_send), 0);
    chk("rst_active", 32'(active), 0);
    model_reset();
    q.delete();
    req = '0; valid = 1'b0; busy = 1'b0; idle_busy = 1'b0;
    no_rise = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_L = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, idx;
    model_reset();
    @(negedge clk);
    do_reset();

    // two requesters, 0 wins first, then 2
    req = 4'b0101; req_byte = 32'h44332211;
    fix_rd = 0; fix_rh = 3;
    tick();
    chk("t36_gnt0", 32'(gnt), 1);
    chk("t36_write", 32'(write), 1);
    chk("t36_bs0", 32'(byte_send), 'h11);
    wait_for(1, 20, n);
    chk("t36_lat", n, 5);
    chk("t36_done", 32'(done), 1);
    wait_for(0, 20, n);
    chk("t36_gnt2", 32'(gnt), 4);
    chk("t36_bs2", 32'(byte_send), 'h33);
    req = '0;
    wait_for(3, 20, n);

    // all requesting: strict rotation
    do_reset();
    fix_rd = -1; fix_rh = -1; n_done = 0;
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      wait_for(0, 30, n);
      idx = -1;
      for (int j = 0; j < N; j++) if (gnt[j]) idx = j;
      chk("t37_order", idx, t % 4);
    end
    req = '0;
    wait_for(3, 30, n);
    chk("t37_ndone", n_done, 8);

    // busy never rises: timeout
    do_reset();
    n_done = 0; n_err = 0;
    no_rise = 1'b1; req = 4'b0001;
    wait_for(0, 10, n);
    req = '0;
    wait_for(2, 300, n);
    chk("t38_lat", n, 256);
    chk("t38_err", 32'(err), 1);
    chk("t38_gnt", 32'(gnt), 0);
    chk("t38_active", 32'(active), 0);
    no_rise = 1'b0;
    tick();
    chk("t38_ndone", n_done, 0);
    chk("t38_nerr", n_err, 1);

    // rx forwarding in WAIT_DONE, dropped in IDLE
    do_reset();
    fix_rd = 0; fix_rh = 4; req = 4'b0010;
    wait_for(0, 10, n);
    tick();
    tick();
    valid = 1'b1; byte_recv = 8'hA5;
    tick();
    chk("t39_rv", 32'(rsp_valid), 2);
    chk("t39_rb", 32'(rsp_byte), 'hA5);
    valid = 1'b0; req = '0;
    wait_for(3, 20, n);
    valid = 1'b1; byte_recv = 8'h5A;
    tick();
    chk("t39_idle_rv", 32'(rsp_valid), 0);
    valid = 1'b0;
    tick();

    // reset in WAIT_DONE, then normal grant
    do_reset();
    fix_rd = 0; fix_rh = 8; req = 4'b0001;
    wait_for(0, 10, n);
    tick();
    tick();
    do_reset();
    fix_rh = -1; fix_rd = -1;
    req = 4'b0001;
    tick();
    chk("t40_gnt", 32'(gnt), 1);
    chk("t40_write", 32'(write), 1);
    req = '0;
    wait_for(3, 20, n);

    // busy high in IDLE blocks the grant
    do_reset();
    idle_busy = 1'b1; busy = 1'b1; req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t41_nowrite", 32'(write), 0);
      chk("t41_nognt", 32'(gnt), 0);
    end
    idle_busy = 1'b0; busy = 1'b0;
    tick();
    chk("t41_gnt", 32'(gnt), 1);
    chk("t41_write", 32'(write), 1);
    req = '0;
    wait_for(3, 20, n);

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      no_rise = ($urandom % 60 == 0);
      tick();
      req = N'($urandom & $urandom);
      req_byte = $urandom;
      valid = ($urandom % 4 == 0);
      byte_recv = 8'($urandom);
      idle_busy = ($urandom % 5 == 0);
      if ($urandom % 1200 == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
